// File: rtl/out_result_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | out_result_writer_if : classifier-result handshake and BRAM write port     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface out_result_writer_if #(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 8
);
  logic                         result_valid;
  logic                         result_ready;
  logic [NUM_CLASSES*CNT_W-1:0] result_counts;
  logic [31:0]                  Output_Addr;
  logic                         bram_en;
  logic [3:0]                   bram_we;
  logic [31:0]                  bram_addr;
  logic [31:0]                  bram_din;
  logic                         TX_done;
  logic                         wrap_pulse;

  modport master (
    input  result_valid, result_counts, Output_Addr,
    output result_ready, bram_en, bram_we, bram_addr, bram_din, TX_done, wrap_pulse
  );

  modport slave (
    output result_valid, result_counts, Output_Addr,
    input  result_ready, bram_en, bram_we, bram_addr, bram_din, TX_done, wrap_pulse
  );
endinterface
`default_nettype wire

// File: rtl/out_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | out_result_writer : sequential argmax over per-class spike counts, writes  |
// | one result word per sample to BRAM and strobes the address generator.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module out_result_writer #(
  parameter logic [31:0] BRAM_MAX_ADDR = 32'h00002000,
  parameter int          NUM_CLASSES   = 10,
  parameter int          CNT_W         = 8
) (
  input wire                  clk,
  input wire                  resetn,
  out_result_writer_if.master bus
);

  localparam int         VEC_W    = NUM_CLASSES * CNT_W;
  localparam logic [7:0] LAST_IDX = 8'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    CHECK  = 3'd2,
    WRITE  = 3'd3,
    DONE1  = 3'd4,
    DONE2  = 3'd5,
    SETTLE = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   counts_q, counts_d;
  logic [7:0]         scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [7:0]         max_idx_q, max_idx_d;
  logic [31:0]        addr_q, addr_d;
  logic               skip_q, skip_d;
  logic [15:0]        sample_id_q, sample_id_d;
  logic [31:0]        bram_addr_q, bram_addr_d;
  logic [31:0]        bram_din_q, bram_din_d;
  logic               wrap_d;
  logic               ready_q, en_q, tx_done_q, wrap_q;
  logic [3:0]         we_q;
  logic [CNT_W-1:0]   cur_cnt;
  logic [7:0]         max_ext;

  // Captured counts shift down one class per SCAN cycle, so the current class is always the low slice.
  assign cur_cnt = counts_q[CNT_W-1:0];
  assign max_ext = 8'(max_q);

  always_comb begin
    state_d     = state_q;
    counts_d    = counts_q;
    scan_idx_d  = scan_idx_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    addr_d      = addr_q;
    skip_d      = skip_q;
    sample_id_d = sample_id_q;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    wrap_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.result_valid && ready_q) begin
          counts_d   = bus.result_counts;
          scan_idx_d = 8'd0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if ((scan_idx_q == 8'd0) || (cur_cnt > max_q)) begin
          max_d     = cur_cnt;
          max_idx_d = scan_idx_q;
        end
        counts_d = counts_q >> CNT_W;
        if (scan_idx_q == LAST_IDX) begin
          scan_idx_d = 8'd0;
          state_d    = CHECK;
        end else begin
          scan_idx_d = scan_idx_q + 8'd1;
        end
      end
      CHECK: begin
        addr_d = bus.Output_Addr;
        if (bus.Output_Addr < BRAM_MAX_ADDR) begin
          bram_addr_d = bus.Output_Addr;
          bram_din_d  = {sample_id_q, max_ext, max_idx_q};
          state_d     = WRITE;
        end else begin
          // Out-of-range slot: strobe the generator past it, then retry the same result.
          skip_d  = 1'b1;
          wrap_d  = 1'b1;
          state_d = DONE1;
        end
      end
      WRITE: begin
        sample_id_d = sample_id_q + 16'd1;
        state_d     = DONE1;
      end
      DONE1:  state_d = DONE2;
      DONE2:  state_d = SETTLE;
      SETTLE: begin
        if (skip_q) begin
          skip_d  = 1'b0;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free and aligned with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      counts_q    <= '0;
      scan_idx_q  <= 8'd0;
      max_q       <= '0;
      max_idx_q   <= 8'd0;
      addr_q      <= 32'd0;
      skip_q      <= 1'b0;
      sample_id_q <= 16'd0;
      bram_addr_q <= 32'd0;
      bram_din_q  <= 32'd0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 4'h0;
      tx_done_q   <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counts_q    <= counts_d;
      scan_idx_q  <= scan_idx_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      addr_q      <= addr_d;
      skip_q      <= skip_d;
      sample_id_q <= sample_id_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      ready_q     <= (state_d == IDLE);
      en_q        <= (state_d == WRITE);
      we_q        <= (state_d == WRITE) ? 4'hF : 4'h0;
      tx_done_q   <= (state_d == DONE1) || (state_d == DONE2);
      wrap_q      <= wrap_d;
    end
  end

  assign bus.result_ready = ready_q;
  assign bus.bram_en      = en_q;
  assign bus.bram_we      = we_q;
  assign bus.bram_addr    = bram_addr_q;
  assign bus.bram_din     = bram_din_q;
  assign bus.TX_done      = tx_done_q;
  assign bus.wrap_pulse   = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_out_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_out_result_writer : directed bench with write-back scoreboard and an    |
// | out_addr_gen model driving Output_Addr.                                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_out_result_writer;

  localparam int          NC   = 10;
  localparam int          CW   = 8;
  localparam logic [31:0] MAXA = 32'h00002000;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  out_result_writer_if #(.NUM_CLASSES(NC), .CNT_W(CW)) bus ();

  out_result_writer #(
    .BRAM_MAX_ADDR(MAXA),
    .NUM_CLASSES  (NC),
    .CNT_W        (CW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address generator model: advances on the rising edge of TX_done, shows MAXA for one slot, then wraps.
  logic [31:0] model_addr;
  logic        tx_prev;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_addr <= 32'd0;
      tx_prev    <= 1'b0;
    end else begin
      tx_prev <= bus.TX_done;
      if (bus.TX_done && !tx_prev)
        model_addr <= (model_addr == MAXA) ? 32'd0 : model_addr + 32'd4;
    end
  end
  assign bus.Output_Addr = model_addr;

  // Scoreboard entries are {addr, din}.
  logic [63:0] exp_q[$];
  logic [63:0] e_mon;
  int wr_cnt = 0, tx_pulses = 0, tx_run = 0, wrap_cycles = 0;

  always @(negedge clk) begin
    if (bus.bram_en) begin
      wr_cnt++;
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        chk("bram_addr", bus.bram_addr, e_mon[63:32]);
        chk("bram_din", bus.bram_din, e_mon[31:0]);
        chk("bram_we", {28'd0, bus.bram_we}, 32'hF);
      end
    end
    if (bus.TX_done) begin
      tx_run++;
    end else if (tx_run != 0) begin
      chk("tx_width", 32'(tx_run), 32'd2);
      tx_pulses++;
      tx_run = 0;
    end
    if (bus.wrap_pulse) wrap_cycles++;
  end

  function automatic logic [31:0] exp_din(input logic [NC*CW-1:0] c, input logic [15:0] id);
    logic [7:0]    bi;
    logic [CW-1:0] bm;
    bi = 8'd0;
    bm = c[CW-1:0];
    for (int i = 1; i < NC; i++) begin
      if (c[i*CW +: CW] > bm) begin
        bm = c[i*CW +: CW];
        bi = 8'(i);
      end
    end
    return {id, 8'(bm), bi};
  endfunction

  task automatic send(input logic [NC*CW-1:0] c, input bit keep, output int acc);
    int k;
    @(negedge clk);
    bus.result_counts = c;
    bus.result_valid  = 1'b1;
    k = 0;
    while (!bus.result_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("accept_in_time", 32'(k < 200), 32'd1);
    acc = cyc;
    @(posedge clk);
    if (!keep) begin
      @(negedge clk);
      bus.result_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.result_ready}, 32'd0);
    chk("rst_en", {31'd0, bus.bram_en}, 32'd0);
    chk("rst_we", {28'd0, bus.bram_we}, 32'd0);
    chk("rst_tx", {31'd0, bus.TX_done}, 32'd0);
    chk("rst_wrap", {31'd0, bus.wrap_pulse}, 32'd0);
    chk("rst_addr", bus.bram_addr, 32'd0);
    chk("rst_din", bus.bram_din, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.result_ready}, 32'd1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !bus.result_ready) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC*CW-1:0] c;
    int acc0, acc1, acc2, k, pre_wr, pre_tx;

    bus.result_valid  = 1'b0;
    bus.result_counts = '0;

    // Single sample, class 3 wins
    do_reset();
    pre_wr = wr_cnt;
    pre_tx = tx_pulses;
    for (int i = 0; i < NC; i++) c[i*CW +: CW] = (i == 3) ? 8'd9 : 8'd2;
    exp_q.push_back({32'h0, 32'h0000_0903});
    send(c, 1'b0, acc0);
    k = 1;
    while (!bus.result_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_return", 32'(k), 32'd16);
    wait_drain();
    chk("single_writes", 32'(wr_cnt - pre_wr), 32'd1);
    chk("single_tx", 32'(tx_pulses - pre_tx), 32'd1);

    // Tie between classes 2 and 5 keeps the lower index
    c = '0;
    c[2*CW +: CW] = 8'd7;
    c[5*CW +: CW] = 8'd7;
    exp_q.push_back({32'h4, 32'h0001_0702});
    send(c, 1'b0, acc0);
    wait_drain();

    // All counts zero selects class 0
    c = '0;
    exp_q.push_back({32'h8, 32'h0002_0000});
    send(c, 1'b0, acc0);
    wait_drain();

    // Back-to-back with result_valid held high
    do_reset();
    for (int i = 0; i < NC; i++) c[i*CW +: CW] = 8'($urandom_range(0, 255));
    exp_q.push_back({32'h0, exp_din(c, 16'd0)});
    send(c, 1'b1, acc0);
    for (int i = 0; i < NC; i++) c[i*CW +: CW] = 8'($urandom_range(0, 3));
    exp_q.push_back({32'h4, exp_din(c, 16'd1)});
    send(c, 1'b1, acc1);
    for (int i = 0; i < NC; i++) c[i*CW +: CW] = 8'($urandom_range(0, 255));
    exp_q.push_back({32'h8, exp_din(c, 16'd2)});
    send(c, 1'b0, acc2);
    chk("b2b_spacing_1", 32'(acc1 - acc0), 32'd16);
    chk("b2b_spacing_2", 32'(acc2 - acc1), 32'd16);
    wait_drain();

    // Reset while the argmax scan is running discards the sample
    do_reset();
    pre_wr = wr_cnt;
    pre_tx = tx_pulses;
    for (int i = 0; i < NC; i++) c[i*CW +: CW] = 8'(i + 1);
    send(c, 1'b0, acc0);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt - pre_wr), 32'd0);
    chk("abort_no_tx", 32'(tx_pulses + tx_run - pre_tx), 32'd0);

    // Fill the whole region, then the wrap slot is skipped and the result reissued at 0
    chk("wrap_none_yet", 32'(wrap_cycles), 32'd0);
    pre_wr = wr_cnt;
    pre_tx = tx_pulses;
    for (int i = 0; i < 2049; i++) begin
      for (int j = 0; j < NC; j++)
        c[j*CW +: CW] = (i % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 2));
      if (i < 2048) exp_q.push_back({32'(i * 4), exp_din(c, 16'(i))});
      else          exp_q.push_back({32'h0, exp_din(c, 16'd2048)});
      send(c, 1'b0, acc0);
    end
    wait_drain();
    chk("wrap_pulse_cycles", 32'(wrap_cycles), 32'd1);
    chk("wrap_writes", 32'(wr_cnt - pre_wr), 32'd2049);
    chk("wrap_tx_pulses", 32'(tx_pulses - pre_tx), 32'd2050);
    chk("wrap_final_addr", model_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_result_writer.md
# out_result_writer

Result write-back stage between the SNN classifier core and the output BRAM. Accepts one packed vector of per-class spike counts per sample and finds the winning class with a sequential argmax. Writes one 32-bit result word to the BRAM at the address supplied by `out_addr_gen`, then pulses `TX_done` so the address generator advances to the next slot.

## Interface

Parameters:
- `BRAM_MAX_ADDR`, 32'h00002000: byte size of the result region. Valid write addresses are 0 .. `BRAM_MAX_ADDR`-4.
- `NUM_CLASSES`, 10: number of output neurons. Range 2..256.
- `CNT_W`, 8: width of each spike count. Range 1..8.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `result_valid` in 1: core presents a result.
- `result_ready` out 1: block can accept a result.
- `result_counts` in `NUM_CLASSES*CNT_W`: class i occupies bits [i*CNT_W +: CNT_W].
- `Output_Addr` in 32: current slot address from `out_addr_gen`.
- `bram_en` out 1: BRAM port enable.
- `bram_we` out 4: byte write enables.
- `bram_addr` out 32: BRAM byte address.
- `bram_din` out 32: BRAM write data.
- `TX_done` out 1: registered, glitch-free strobe that advances `out_addr_gen` on its rising edge.
- `wrap_pulse` out 1: one-cycle flag set when the result region wraps.

## Operation

- FSM states: IDLE, SCAN, CHECK, WRITE, DONE1, DONE2, SETTLE.
- IDLE:
  - `result_ready`=1; it is 1 only in IDLE.
  - On `result_valid`&`result_ready`, capture `result_counts` into an internal register, then go to SCAN.
- SCAN (`NUM_CLASSES` cycles):
  - Cycle k compares class k against the running maximum; class 0 initialises the maximum.
  - Replacement only on strictly greater, so a tie keeps the lowest index.
  - Then go to CHECK.
- CHECK (1 cycle): latch `Output_Addr` into `addr_q`.
  - If `addr_q` < `BRAM_MAX_ADDR`: go to WRITE.
  - Otherwise (the generator presents `BRAM_MAX_ADDR` for one slot before returning to 0): skip the write, set `skip_q`=1 and `wrap_pulse`=1 for this cycle, then go to DONE1.
- WRITE (1 cycle):
  - `bram_en`=1, `bram_we`=4'hF, `bram_addr`=`addr_q`.
  - `bram_din` = {`sample_id`[15:0], zero-extended max count [7:0], class index [7:0]}.
  - Increment `sample_id` (16-bit, wraps 0xFFFF→0). Go to DONE1.
- DONE1, DONE2: `TX_done`=1 (two-cycle-wide pulse), then go to SETTLE.
- SETTLE (1 cycle): lets `Output_Addr` update.
  - If `skip_q`: clear it and go to CHECK, re-issuing the same result at the wrapped address.
  - Else: go to IDLE.
- A skipped slot does not consume a `sample_id`.
- Outside WRITE: `bram_en`=0, `bram_we`=0, and `bram_addr`/`bram_din` hold their last values.
- Reset (asynchronous, any state): FSM→IDLE; `sample_id`, `skip_q`, `addr_q` → 0; all outputs → 0 except `result_ready`, which becomes 1 after reset deasserts. A result in flight is discarded with no BRAM write and no `TX_done`.

## Timing

- Accept at edge T. SCAN covers T+1..T+N, where N=`NUM_CLASSES`.
- CHECK at T+N+1; WRITE at T+N+2.
- `TX_done` high in T+N+3 and T+N+4; SETTLE at T+N+5.
- `result_ready` returns high at T+N+6. Throughput is one sample per N+6 cycles.
- Wrap case adds 4 cycles (DONE1, DONE2, SETTLE, CHECK) before WRITE.
- `TX_done` has a minimum low time of 2 cycles between pulses.
- `result_valid` may stay high back-to-back; `result_counts` is sampled only at accept.

## Test plan

- Reset, then counts class3=9, all others 2, `Output_Addr`=0 → single write at addr 0, `bram_din`=32'h0000_0903; `TX_done` high exactly 2 cycles; `result_ready` low for 16 cycles (N=10).
- Tie: class2=7, class5=7, others 0 → `bram_din`[7:0]=2, [15:8]=7.
- Wrap: model `out_addr_gen`, issue 2049 samples → writes at 0x0000..0x1FFC. Sample 2049:
  - `Output_Addr`=0x2000 → no write, `wrap_pulse` one cycle, extra `TX_done`.
  - Then a write at 0x0000 with `sample_id`=2048.
- Back-to-back: `result_valid` held high for 3 samples → accepts spaced 16 cycles apart; `sample_id` 0,1,2; addresses 0,4,8.
- Reset mid-SCAN (cycle T+4) → no BRAM write, `TX_done` stays 0. The next sample writes with `sample_id`=0.
- All counts 0 → class 0 selected, `bram_din`[15:0]=16'h0000.
